// File: rtl/duty_btn_ctrl_if.sv
// Button/strobe bundle between the raw push-buttons and the clkduty strobe consumer.
// The master drives the raw buttons; the slave (duty_btn_ctrl) drives strobes and status.
interface duty_btn_ctrl_if;
    logic btn_inc_n;
    logic btn_dec_n;
    logic inc_o;
    logic dec_o;
    logic inc_db_n;
    logic dec_db_n;
    logic lock;

    modport master (
        output btn_inc_n, btn_dec_n,
        input  inc_o, dec_o, inc_db_n, dec_db_n, lock
    );

    modport slave (
        input  btn_inc_n, btn_dec_n,
        output inc_o, dec_o, inc_db_n, dec_db_n, lock
    );
endinterface

// File: rtl/duty_btn_ctrl.sv
// Button conditioning for clkduty: synchronise, debounce, single-step and auto-repeat
// inc/dec strobes (active-low, one cycle), with lockout while both buttons are held.
module duty_btn_deb #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clkin,
    input  logic reset,
    input  logic raw_n,
    output logic stable_n
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // The flip happens on the sample after the counter saturates, so a disagreement
    // must persist DEBOUNCE_CYCLES full cycles beyond the first differing sample.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync     <= '1;
            cnt      <= '0;
            stable_n <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw_n};
            if (synced == stable_n) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                stable_n <= synced;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module duty_btn_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic            clkin,
    input  logic            reset,
    duty_btn_ctrl_if.slave  bus
);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    logic [1:0] raw_n;
    logic [1:0] stable_n;

    assign raw_n = {bus.btn_dec_n, bus.btn_inc_n};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        duty_btn_deb #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clkin    (clkin),
            .reset    (reset),
            .raw_n    (raw_n[g]),
            .stable_n (stable_n[g])
        );
    end

    state_t         state, state_nxt;
    logic [TW-1:0]  tmr, tmr_nxt;
    logic           dir, dir_nxt;       // 0 = inc latched, 1 = dec latched
    logic           inc_q, dec_q;
    logic           inc_nxt, dec_nxt;
    logic           fire;

    logic press_i, press_d, held, other;

    assign press_i = ~stable_n[0];
    assign press_d = ~stable_n[1];
    assign held    = dir ? press_d : press_i;
    assign other   = dir ? press_i : press_d;

    always_ff @(posedge clkin) begin
        if (reset) begin
            state <= IDLE;
            tmr   <= '0;
            dir   <= 1'b0;
            inc_q <= 1'b1;
            dec_q <= 1'b1;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            dir   <= dir_nxt;
            inc_q <= inc_nxt;
            dec_q <= dec_nxt;
        end
    end

    // Release beats lockout, and both beat a coinciding timer expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press_i && press_d)      state_nxt = LOCK;
                else if (press_i || press_d) state_nxt = DELAY;
            end
            DELAY: begin
                if (!held)                                  state_nxt = IDLE;
                else if (other)                             state_nxt = LOCK;
                else if (tmr == TW'(REPEAT_DELAY - 1))      state_nxt = REPEAT;
            end
            REPEAT: begin
                if (!held)       state_nxt = IDLE;
                else if (other)  state_nxt = LOCK;
            end
            LOCK: begin
                if (!press_i && !press_d) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire    = 1'b0;
        tmr_nxt = tmr;
        dir_nxt = dir;
        case (state)
            IDLE: begin
                if (press_i ^ press_d) begin
                    fire    = 1'b1;
                    tmr_nxt = '0;
                    dir_nxt = press_d;
                end
            end
            DELAY: begin
                if (held && !other) begin
                    if (tmr == TW'(REPEAT_DELAY - 1)) begin
                        fire    = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (held && !other) begin
                    if (tmr == TW'(REPEAT_RATE - 1)) begin
                        fire    = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
            end
            default: tmr_nxt = '0;
        endcase
        inc_nxt = ~(fire & ~dir_nxt);
        dec_nxt = ~(fire & dir_nxt);
    end

    assign bus.inc_o    = inc_q;
    assign bus.dec_o    = dec_q;
    assign bus.inc_db_n = stable_n[0];
    assign bus.dec_db_n = stable_n[1];
    assign bus.lock     = (state == LOCK);

    strobe_exclusive: assert property (@(posedge clkin) disable iff (reset) (inc_q | dec_q));
endmodule
